// File: rtl/adex_pkg.sv
// Shared AdEx definitions: Q8.8 state type, reset voltage, and the
// scheduler FSM encoding. The neuron core imports the same package.
package adex_pkg;

    localparam int QFRAC = 8;

    typedef logic signed [15:0] q88_t;

    // -65.0 mV in Q8.8
    localparam q88_t V_RESET_INIT = 16'shBF00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_WBACK
    } sched_state_t;

endpackage

// File: rtl/adex_evt_fifo.sv
// Small synchronous event FIFO. A push into a full FIFO succeeds only
// when a pop happens in the same cycle; otherwise it is dropped and
// o_drop pulses for one cycle. DEPTH must be a power of 2, >= 2.
module adex_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_empty,
    output logic         o_drop,
    output logic [W-1:0] o_data
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_drop    = i_push && w_full && !w_do_pop;
    assign o_data    = r_mem[r_rp];

    // Storage, pointers and occupancy; pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_do_pop) r_rp <= r_rp + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/adex_neuron_scheduler.sv
// Sweeps N_NEURONS virtual neurons through one shared AdEx core per tick.
// Refractory neurons are skipped (one cycle each); issued neurons go
// through ISSUE/WAIT/WBACK and spikes are queued in the event FIFO.
module adex_neuron_scheduler
    import adex_pkg::*;
#(
    parameter int   N_NEURONS    = 4,
    parameter int   IDX_W        = 4,
    parameter int   REFRAC_STEPS = 2,
    parameter int   FIFO_DEPTH   = 4,
    parameter q88_t V_RESET_INIT = adex_pkg::V_RESET_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_tick,
    output logic             o_core_start,
    output logic [IDX_W-1:0] o_core_idx,
    output logic [15:0]      o_core_v,
    output logic [15:0]      o_core_w,
    input  logic             i_core_done,
    input  logic [15:0]      i_core_v_new,
    input  logic [15:0]      i_core_w_new,
    input  logic             i_core_spike,
    output logic             o_evt_valid,
    output logic [IDX_W-1:0] o_evt_idx,
    input  logic             i_evt_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_evt_drop,
    output logic [15:0]      o_step_cnt
);
    localparam int               PTR_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [2:0]       REFRAC   = REFRAC_STEPS[2:0];

    sched_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0] r_ptr;
    q88_t             r_v      [N_NEURONS];
    q88_t             r_w      [N_NEURONS];
    logic [2:0]       r_refrac [N_NEURONS];

    q88_t  r_v_res;
    q88_t  r_w_res;
    logic  r_spk_res;
    logic  r_drop;      // enable fell during ISSUE/WAIT: stop after WBACK
    logic  r_overrun;
    logic  r_evt_drop;
    logic [15:0] r_step_cnt;

    logic [PTR_W-1:0] w_sel;
    logic w_last;
    logic w_adv;
    logic w_ptr_inc;
    logic w_dec;
    logic w_wb;
    logic w_step_inc;
    logic w_push;
    logic w_fifo_empty;
    logic w_fifo_drop;

    assign w_sel  = r_ptr[PTR_W-1:0];
    assign w_last = (r_ptr == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_ptr_inc   = 1'b0;
        w_dec       = 1'b0;
        w_wb        = 1'b0;
        w_step_inc  = 1'b0;
        unique case (r_state)
            S_IDLE:   if (i_tick && i_enable) w_state_nxt = S_SELECT;
            S_SELECT: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_refrac[w_sel] != 3'd0) begin
                    w_dec = 1'b1;
                    w_adv = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT:   if (i_core_done) w_state_nxt = S_WBACK;
            S_WBACK: begin
                w_wb = 1'b1;
                if (!i_enable || r_drop) w_state_nxt = S_IDLE;
                else                     w_adv       = 1'b1;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_adv) begin
            if (w_last) begin
                w_step_inc  = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_ptr_inc   = 1'b1;
                w_state_nxt = S_SELECT;
            end
        end
    end

    // Pointer: parked at 0 whenever idle so every sweep starts at neuron 0.
    always_ff @(posedge clk) begin
        if (reset || w_state_nxt == S_IDLE) r_ptr <= '0;
        else if (w_ptr_inc)                 r_ptr <= r_ptr + 1'b1;
    end

    // Per-neuron state: write-back of core results and refractory countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i]      <= V_RESET_INIT;
                r_w[i]      <= '0;
                r_refrac[i] <= '0;
            end
        end else if (w_wb) begin
            r_v[w_sel] <= r_v_res;
            r_w[w_sel] <= r_w_res;
            if (r_spk_res) r_refrac[w_sel] <= REFRAC;
        end else if (w_dec) begin
            r_refrac[w_sel] <= r_refrac[w_sel] - 3'd1;
        end
    end

    // Capture core results on done (only meaningful in WAIT) and track an
    // enable drop that must take effect after the pending write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_res   <= '0;
            r_w_res   <= '0;
            r_spk_res <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            if (r_state == S_WAIT && i_core_done) begin
                r_v_res   <= i_core_v_new;
                r_w_res   <= i_core_w_new;
                r_spk_res <= i_core_spike;
            end
            if (r_state == S_ISSUE || r_state == S_WAIT) r_drop <= r_drop | !i_enable;
            else                                         r_drop <= 1'b0;
        end
    end

    // Sweep counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cnt <= '0;
            r_overrun  <= 1'b0;
            r_evt_drop <= 1'b0;
        end else begin
            if (w_step_inc) r_step_cnt <= r_step_cnt + 16'd1;
            if (i_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            if (w_fifo_drop) r_evt_drop <= 1'b1;
        end
    end

    assign w_push = w_wb && r_spk_res;

    adex_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_evt_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (r_ptr),
        .i_pop   (i_evt_ready),
        .o_empty (w_fifo_empty),
        .o_drop  (w_fifo_drop),
        .o_data  (o_evt_idx)
    );

    assign o_core_start = (r_state == S_ISSUE);
    assign o_core_idx   = r_ptr;
    assign o_core_v     = r_v[w_sel];
    assign o_core_w     = r_w[w_sel];
    assign o_evt_valid  = !w_fifo_empty;
    assign o_busy       = (r_state != S_IDLE);
    assign o_overrun    = r_overrun;
    assign o_evt_drop   = r_evt_drop;
    assign o_step_cnt   = r_step_cnt;

endmodule
